// File: rtl/laundry_job_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : laundry_job_scheduler                                         |
// | Purpose  : Buffers wash-job requests in a small FIFO and sequences the   |
// |            washing-machine controller one job at a time: launch pulse,   |
// |            program decode, wait for completion, forced cool-down gap and |
// |            an optional watchdog that aborts hung jobs.                   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
// | Parameters                                                               |
// |   DEPTH        job FIFO depth (power of two, >= 2)                        |
// |   GAP_CYCLES   idle cycles forced between jobs (>= 1)                     |
// |   WATCHDOG     unpaused RUN cycles before a job is aborted (>= 2)         |
// | Ports                                                                    |
// |   clk, rst     rising-edge clock, synchronous active-high reset           |
// |   req_valid/req_prog/req_ready   request handshake, 2-bit program         |
// |   pause        hold dispatch of new jobs and freeze the watchdog          |
// |   machine_done completion pulse from the machine                          |
// |   start        one-cycle launch pulse to the machine                      |
// |   double_wash, dry_wash   decoded program, held while the job runs        |
// |   busy         a job is launching, running or in its gap                  |
// |   job_done, job_fault, illegal_prog   one-cycle status pulses             |
// |   queue_count  jobs waiting in the FIFO                                   |
// | Build option                                                             |
// |   SCHED_WATCHDOG_EN  when defined, the watchdog counter and fault path    |
// |                      exist; otherwise RUN waits for machine_done forever  |
// |                      and job_fault is constant 0.                         |
// +--------------------------------------------------------------------------+
module laundry_job_scheduler #(
  parameter int DEPTH      = 4,
  parameter int GAP_CYCLES = 3,
  parameter int WATCHDOG   = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  input  logic [1:0]             req_prog,
  output logic                   req_ready,
  input  logic                   pause,
  input  logic                   machine_done,
  output logic                   start,
  output logic                   double_wash,
  output logic                   dry_wash,
  output logic                   busy,
  output logic                   job_done,
  output logic                   job_fault,
  output logic                   illegal_prog,
  output logic [$clog2(DEPTH):0] queue_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  localparam logic [1:0] PROG_DOUBLE  = 2'b01;
  localparam logic [1:0] PROG_STEAM   = 2'b10;
  localparam logic [1:0] PROG_ILLEGAL = 2'b11;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_chk_depth
    $error("laundry_job_scheduler: DEPTH must be a power of two >= 2");
  end
  if (GAP_CYCLES < 1) begin : g_chk_gap
    $error("laundry_job_scheduler: GAP_CYCLES must be >= 1");
  end
  if (WATCHDOG < 2) begin : g_chk_watchdog
    $error("laundry_job_scheduler: WATCHDOG must be >= 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_RUN    = 2'd2,
    ST_GAP    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       fifo_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             ready_q, ready_d;
  logic             start_q, start_d;
  logic             double_q, double_d;
  logic             dry_q, dry_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             illegal_q, illegal_d;
`ifdef SCHED_WATCHDOG_EN
  localparam int WD_W = $clog2(WATCHDOG);
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             fault_q, fault_d;
`endif

  logic             accept;
  logic             push;
  logic             pop;
  logic             illegal;
  logic [1:0]       head;

  always_comb begin
    // Program 11 completes the handshake but never occupies a FIFO slot.
    accept   = req_valid && ready_q;
    illegal  = accept && (req_prog == PROG_ILLEGAL);
    push     = accept && (req_prog != PROG_ILLEGAL);
    pop      = (state_q == ST_IDLE) && (count_q != '0) && !pause;
    head     = fifo_q[rd_ptr_q];

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
    ready_d   = (count_d != CNT_W'(DEPTH));
    illegal_d = illegal;

    state_d  = state_q;
    start_d  = 1'b0;
    done_d   = 1'b0;
    double_d = double_q;
    dry_d    = dry_q;
    gap_d    = gap_q;
`ifdef SCHED_WATCHDOG_EN
    wd_d     = wd_q;
    fault_d  = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        // Decode at pop time so the program flags are already valid in
        // the same cycle as the start pulse.
        if (pop) begin
          state_d  = ST_LAUNCH;
          start_d  = 1'b1;
          double_d = (head == PROG_DOUBLE);
          dry_d    = (head == PROG_STEAM);
        end
      end
      ST_LAUNCH: begin
        state_d = ST_RUN;
`ifdef SCHED_WATCHDOG_EN
        wd_d    = '0;
`endif
      end
      ST_RUN: begin
        // Completion has priority over a watchdog expiry in the same cycle.
        if (machine_done) begin
          state_d  = ST_GAP;
          done_d   = 1'b1;
          double_d = 1'b0;
          dry_d    = 1'b0;
          gap_d    = '0;
        end
`ifdef SCHED_WATCHDOG_EN
        else if (!pause) begin
          if (wd_q == WD_W'(WATCHDOG - 1)) begin
            state_d  = ST_GAP;
            fault_d  = 1'b1;
            double_d = 1'b0;
            dry_d    = 1'b0;
            gap_d    = '0;
          end else begin
            wd_d = wd_q + 1'b1;
          end
        end
`endif
      end
      ST_GAP: begin
        // The first GAP cycle carries the done/fault pulse; GAP_CYCLES
        // further cycles of cool-down follow before IDLE can dispatch.
        if (gap_q == GAP_W'(GAP_CYCLES)) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      gap_q     <= '0;
      ready_q   <= 1'b1;
      start_q   <= 1'b0;
      double_q  <= 1'b0;
      dry_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
`ifdef SCHED_WATCHDOG_EN
      wd_q      <= '0;
      fault_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      gap_q     <= gap_d;
      ready_q   <= ready_d;
      start_q   <= start_d;
      double_q  <= double_d;
      dry_q     <= dry_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
`ifdef SCHED_WATCHDOG_EN
      wd_q      <= wd_d;
      fault_q   <= fault_d;
`endif
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= req_prog;
    end
  end

  assign req_ready    = ready_q;
  assign start        = start_q;
  assign double_wash  = double_q;
  assign dry_wash     = dry_q;
  assign busy         = busy_q;
  assign job_done     = done_q;
  assign illegal_prog = illegal_q;
  assign queue_count  = count_q;
`ifdef SCHED_WATCHDOG_EN
  assign job_fault    = fault_q;
`else
  assign job_fault    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_laundry_job_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module   : tb_laundry_job_scheduler                                      |
// | Purpose  : Self-checking bench for laundry_job_scheduler. Accepted       |
// |            programs are queued as expectations and compared against the  |
// |            decoded flags whenever the DUT issues a start pulse.          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_laundry_job_scheduler;

  localparam int DEPTH      = 4;
  localparam int GAP_CYCLES = 3;
  localparam int WATCHDOG   = 64;

  logic                   clk          = 1'b0;
  logic                   rst          = 1'b1;
  logic                   req_valid    = 1'b0;
  logic [1:0]             req_prog     = 2'b00;
  logic                   pause        = 1'b0;
  logic                   machine_done = 1'b0;
  logic                   req_ready;
  logic                   start;
  logic                   double_wash;
  logic                   dry_wash;
  logic                   busy;
  logic                   job_done;
  logic                   job_fault;
  logic                   illegal_prog;
  logic [$clog2(DEPTH):0] queue_count;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_starts = 0;
  logic [1:0] exp_q[$];
  logic [1:0] mon_prog;

  laundry_job_scheduler #(
    .DEPTH      (DEPTH),
    .GAP_CYCLES (GAP_CYCLES),
    .WATCHDOG   (WATCHDOG)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_prog     (req_prog),
    .req_ready    (req_ready),
    .pause        (pause),
    .machine_done (machine_done),
    .start        (start),
    .double_wash  (double_wash),
    .dry_wash     (dry_wash),
    .busy         (busy),
    .job_done     (job_done),
    .job_fault    (job_fault),
    .illegal_prog (illegal_prog),
    .queue_count  (queue_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Scoreboard: every launch must match the oldest accepted legal program.
  always @(negedge clk) begin
    if (start) begin
      n_starts++;
      check_eq("start_has_queued_job", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        mon_prog = exp_q.pop_front();
        check_eq("launch_double_wash", double_wash, mon_prog == 2'b01);
        check_eq("launch_dry_wash", dry_wash, mon_prog == 2'b10);
      end
    end
  end

  task automatic check_reset(input string pfx);
    check_eq({pfx, "_start"}, start, 0);
    check_eq({pfx, "_double_wash"}, double_wash, 0);
    check_eq({pfx, "_dry_wash"}, dry_wash, 0);
    check_eq({pfx, "_busy"}, busy, 0);
    check_eq({pfx, "_job_done"}, job_done, 0);
    check_eq({pfx, "_job_fault"}, job_fault, 0);
    check_eq({pfx, "_illegal"}, illegal_prog, 0);
    check_eq({pfx, "_queue_count"}, queue_count, 0);
    check_eq({pfx, "_req_ready"}, req_ready, 1);
  endtask

  // Called at a negedge with req_ready known high; returns one cycle later.
  task automatic push_one(input logic [1:0] p);
    req_valid = 1'b1;
    req_prog  = p;
    if (p != 2'b11) exp_q.push_back(p);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_start(input string tag, output int cycles);
    cycles = 0;
    while (!start && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
    check_eq(tag, start, 1);
  endtask

  // From the launch cycle: run a few cycles, complete, then sit out the gap.
  task automatic finish_job(input string tag);
    repeat (3) @(negedge clk);
    machine_done = 1'b1;
    @(negedge clk);
    machine_done = 1'b0;
    check_eq({tag, "_job_done"}, job_done, 1);
    check_eq({tag, "_no_fault"}, job_fault, 0);
    check_eq({tag, "_flags_clear"}, double_wash | dry_wash, 0);
    repeat (GAP_CYCLES + 1) @(negedge clk);
  endtask

`ifdef SCHED_WATCHDOG_EN
  // From the launch cycle: count unpaused RUN cycles until a status pulse.
  task automatic run_to_watchdog(input string tag, input bit collide);
    int unp   = 0;
    bit ended = 1'b0;
    for (int c = 1; c <= 200 && !ended; c++) begin
      @(negedge clk);
      if (job_fault || job_done) begin
        ended = 1'b1;
      end else begin
        pause = !collide && (c >= 20) && (c < 30) && (c % 2 == 1);
        if (!pause) unp++;
        if (collide && unp == WATCHDOG) machine_done = 1'b1;
      end
    end
    pause        = 1'b0;
    machine_done = 1'b0;
    if (collide) begin
      check_eq({tag, "_done_wins"}, job_done, 1);
      check_eq({tag, "_no_fault"}, job_fault, 0);
    end else begin
      check_eq({tag, "_fault"}, job_fault, 1);
      check_eq({tag, "_no_done"}, job_done, 0);
      check_eq({tag, "_unpaused_cycles"}, unp, WATCHDOG);
      check_eq({tag, "_flags_clear"}, double_wash | dry_wash, 0);
    end
    check_eq({tag, "_busy_gap"}, busy, 1);
    repeat (GAP_CYCLES + 1) @(negedge clk);
  endtask
`endif

  initial begin
    int cyc;
    int starts_before;
    int model_cnt;
    logic [1:0] fill_progs [5];
    bit saw_fault;

    fill_progs = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b01};

    repeat (3) @(negedge clk);
    check_reset("por");
    rst = 1'b0;
    @(negedge clk);

    // Single double-wash job with a second job queued behind it.
    push_one(2'b01);
    check_eq("qc_after_push", queue_count, 1);
    check_eq("no_start_yet", start, 0);
    @(negedge clk);
    check_eq("start_latency", start, 1);
    @(negedge clk);
    check_eq("start_single_cycle", start, 0);
    push_one(2'b10);
    @(negedge clk);
    check_eq("double_wash_held", double_wash, 1);
    check_eq("busy_running", busy, 1);
    machine_done = 1'b1;
    @(negedge clk);
    machine_done = 1'b0;
    check_eq("job_done_pulse", job_done, 1);
    check_eq("double_wash_cleared", double_wash, 0);
    wait_start("second_launch", cyc);
    check_eq("gap_before_next_start", cyc >= GAP_CYCLES + 2, 1);
    finish_job("job2");
    check_eq("idle_after_job2", busy, 0);

    // Illegal program is consumed and dropped.
    starts_before = n_starts;
    push_one(2'b11);
    check_eq("illegal_pulse", illegal_prog, 1);
    check_eq("illegal_not_queued", queue_count, 0);
    @(negedge clk);
    check_eq("illegal_single_cycle", illegal_prog, 0);
    repeat (4) @(negedge clk);
    check_eq("illegal_no_start", n_starts, starts_before);
    check_eq("illegal_not_busy", busy, 0);

    // Fill the FIFO while paused, then release and drain in order.
    pause     = 1'b1;
    model_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      check_eq("fill_req_ready", req_ready, model_cnt != DEPTH);
      req_valid = 1'b1;
      req_prog  = fill_progs[i];
      if (model_cnt != DEPTH) begin
        exp_q.push_back(fill_progs[i]);
        model_cnt++;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    check_eq("fill_queue_count", queue_count, DEPTH);
    check_eq("fill_not_ready", req_ready, 0);
    repeat (3) @(negedge clk);
    check_eq("paused_no_dispatch", busy, 0);
    pause = 1'b0;
    for (int j = 0; j < DEPTH; j++) begin
      wait_start("drain_launch", cyc);
      finish_job("drain");
    end
    check_eq("drain_all_launched", exp_q.size(), 0);

`ifdef SCHED_WATCHDOG_EN
    push_one(2'b10);
    wait_start("wd_launch", cyc);
    run_to_watchdog("wd", 1'b0);
    push_one(2'b01);
    wait_start("wd_collide_launch", cyc);
    run_to_watchdog("wd_collide", 1'b1);
`else
    push_one(2'b10);
    wait_start("nowd_launch", cyc);
    saw_fault = 1'b0;
    repeat (WATCHDOG + 40) begin
      @(negedge clk);
      saw_fault = saw_fault | job_fault;
    end
    check_eq("nowd_no_fault", saw_fault, 0);
    check_eq("nowd_still_busy", busy, 1);
    check_eq("nowd_dry_held", dry_wash, 1);
    finish_job("nowd");
`endif

    // Reset while running with two jobs queued.
    push_one(2'b00);
    wait_start("rst_launch", cyc);
    push_one(2'b01);
    push_one(2'b10);
    check_eq("rst_pre_queue", queue_count, 2);
    check_eq("rst_pre_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset("rst_run");
    rst = 1'b0;
    exp_q.delete();
    repeat (4) @(negedge clk);
    check_eq("post_rst_idle", busy, 0);
    check_eq("post_rst_empty", queue_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed time %0t expected completion before it", $time);
    $fatal(1, "simulation time limit reached");
  end

endmodule
`default_nettype wire
